// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the SRAM memory controller: FSM state encoding,
// default parameters and the byte-address to SRAM-word mapping.
package sram_mem_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int ADDR_BASE_DEFAULT   = 1024;
    localparam int WAIT_CYCLES_DEFAULT = 3;
    localparam int WORD_IDX_W          = 17;
    localparam int SRAM_ADDR_W         = WORD_IDX_W + 1;

    // Byte address relative to the SRAM base, as a 32-bit word index truncated to 17 bits.
    // address[1:0] drops out through the shift.
    function automatic logic [WORD_IDX_W-1:0] word_index(input logic [31:0] address,
                                                         input logic [31:0] base);
        logic [31:0] offset;
        offset = address - base;
        return WORD_IDX_W'(offset >> 2);
    endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Cycle counter for one 16-bit SRAM access phase. Counts 0..WAIT_CYCLES-1 and
// parks on the last value; flags the final (hold) cycle and the one before it.
module sram_phase_counter
    import sram_mem_controller_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic last,
    output logic pre_last
);

    localparam int CNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;

    logic [CNT_W-1:0] count;

    assign last     = (count == CNT_W'(WAIT_CYCLES - 1));
    assign pre_last = (count == CNT_W'(WAIT_CYCLES - 2));

    // Restart on clear, otherwise advance until the last cycle of the phase.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (!last) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_mem_controller.sv
// Splits one 32-bit pipeline load/store into two 16-bit SRAM accesses
// (low half, then high half). ready stays low while an access is in flight,
// which the pipeline uses as its memory stall.
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [15:0]            SRAM_DQ,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N
);

    state_t                  state;
    logic                    request;
    logic                    accept;
    logic                    is_write;
    logic [WORD_IDX_W-1:0]   word_q;
    logic [15:0]             wdata_hi_q;
    logic                    dq_oe;
    logic [15:0]             dq_out;
    logic                    phase_clear;
    logic                    phase_last;
    logic                    phase_pre_last;

    // A simultaneous read and write request is handled as a write.
    assign request = rd_en | wr_en;
    assign accept  = (state == ST_IDLE) & request;
    assign ready   = (state == ST_DONE) | ((state == ST_IDLE) & ~request);

    // The counter is held at zero outside the access phases and restarts at each phase boundary.
    assign phase_clear = (state == ST_IDLE) | (state == ST_DONE) | phase_last;

    sram_phase_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_phase_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (phase_clear),
        .last     (phase_last),
        .pre_last (phase_pre_last)
    );

    // Only the controller drives DQ, and only during the two phases of a write.
    assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

    // Latch the request on acceptance so the access completes even if the pipeline drops it.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_write   <= wr_en;
            word_q     <= word_index(address, 32'(ADDR_BASE));
            wdata_hi_q <= write_data[31:16];
        end
    end

    // Write data half presented on DQ: low half from the request, high half from the latch.
    always_ff @(posedge clk) begin
        if (accept) begin
            dq_out <= write_data[15:0];
        end else if ((state == ST_LOW) && phase_last) begin
            dq_out <= wdata_hi_q;
        end
    end

    // Sequencer with registered SRAM pins; pin values are set on the edge entering each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            read_data <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            dq_oe     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (request) begin
                        state     <= ST_LOW;
                        SRAM_ADDR <= {word_index(address, 32'(ADDR_BASE)), 1'b0};
                        SRAM_WE_N <= ~wr_en;
                        SRAM_OE_N <= wr_en;
                        dq_oe     <= wr_en;
                    end
                end
                ST_LOW: begin
                    if (phase_last) begin
                        state     <= ST_HIGH;
                        SRAM_ADDR <= {word_q, 1'b1};
                        SRAM_WE_N <= ~is_write;
                        if (!is_write) begin
                            read_data[15:0] <= SRAM_DQ;
                        end
                    end else if (phase_pre_last) begin
                        // Release WE one cycle early so the final cycle holds address/data.
                        SRAM_WE_N <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (phase_last) begin
                        state     <= ST_DONE;
                        SRAM_WE_N <= 1'b1;
                        SRAM_OE_N <= 1'b1;
                        dq_oe     <= 1'b0;
                        if (!is_write) begin
                            read_data[31:16] <= SRAM_DQ;
                        end
                    end else if (phase_pre_last) begin
                        SRAM_WE_N <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
